// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the ALU redundancy controller: FSM encoding
// and the spare-index decode tables for clock enables and voter selects.
package cv32e40p_pkg;

    typedef enum logic [2:0] {
        ALU_NORMAL   = 3'd0,
        ALU_DRAIN    = 3'd1,
        ALU_SWAP     = 3'd2,
        ALU_SETTLE   = 3'd3,
        ALU_DEGRADED = 3'd4,
        ALU_FAILED   = 3'd5
    } alu_red_state_e;

    localparam logic [1:0] RESET_SPARE = 2'd3;

    // Indexed by spare ALU: the spare is clock-gated and never voted.
    localparam logic [3:0] CLK_EN_BY_SPARE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [2:0] SEL_BY_SPARE    [4] = '{3'b110, 3'b101, 3'b011, 3'b111};

endpackage

// File: rtl/cv32e40p_alu_redundancy_ctrl.sv
// Reconfigures the 3-of-4 ALU voter when permanent faults are reported:
// drains the pipeline, swaps the faulty active ALU for the spare, and tracks degradation.
module cv32e40p_alu_redundancy_ctrl
    import cv32e40p_pkg::*;
#(
    parameter int unsigned SWAP_CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            perm_fault_i,
    input  logic                  ex_ready_i,
    input  logic                  alu_busy_i,
    output logic [2:0]            sel_mux_o,
    output logic [3:0]            clock_en_o,
    output logic                  stall_o,
    output logic [3:0]            faulty_alu_o,
    output logic                  degraded_o,
    output logic                  fatal_o,
    output logic [SWAP_CNT_W-1:0] swap_count_o
);

    alu_red_state_e state_q, state_d;
    logic [1:0]     spare_q;
    logic [1:0]     target_q, target_d;
    logic [1:0]     lowest_fault;
    logic [3:0]     faulty_q;
    logic [3:0]     next_faulty;
    logic [3:0]     spare_mask;
    logic [3:0]     active_fault;
    logic [2:0]     next_cnt;
    logic [2:0]     faulty_cnt;
    logic           do_swap;

    assign next_faulty  = faulty_q | perm_fault_i;
    assign spare_mask   = 4'(4'b0001 << spare_q);
    assign active_fault = next_faulty & ~spare_mask;
    assign next_cnt     = 3'(next_faulty[0]) + 3'(next_faulty[1]) + 3'(next_faulty[2]) + 3'(next_faulty[3]);
    assign faulty_cnt   = 3'(faulty_q[0]) + 3'(faulty_q[1]) + 3'(faulty_q[2]) + 3'(faulty_q[3]);

    // Lowest-index faulty active ALU becomes the swap target.
    always_comb begin
        lowest_fault = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (active_fault[i]) lowest_fault = 2'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        do_swap  = 1'b0;
        case (state_q)
            ALU_NORMAL, ALU_DEGRADED: begin
                if (next_cnt >= 3'd3) begin
                    state_d = ALU_FAILED;
                end else if ((|active_fault) && !(|(next_faulty & spare_mask))) begin
                    state_d  = ALU_DRAIN;
                    target_d = lowest_fault;
                end else begin
                    state_d = (next_cnt == 3'd2) ? ALU_DEGRADED : ALU_NORMAL;
                end
            end
            ALU_DRAIN: begin
                if (ex_ready_i && !alu_busy_i) state_d = ALU_SWAP;
            end
            ALU_SWAP: begin
                do_swap = 1'b1;
                state_d = ALU_SETTLE;
            end
            ALU_SETTLE: begin
                state_d = (faulty_cnt == 3'd2) ? ALU_DEGRADED : ALU_NORMAL;
            end
            ALU_FAILED: state_d = ALU_FAILED;
            default:    state_d = ALU_NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ALU_NORMAL;
        else     state_q <= state_d;
    end

    // Configuration, sticky fault mask and swap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            spare_q      <= RESET_SPARE;
            target_q     <= 2'd0;
            faulty_q     <= 4'b0000;
            clock_en_o   <= CLK_EN_BY_SPARE[RESET_SPARE];
            sel_mux_o    <= SEL_BY_SPARE[RESET_SPARE];
            swap_count_o <= '0;
        end else begin
            faulty_q <= next_faulty;
            target_q <= target_d;
            if (do_swap) begin
                spare_q    <= target_q;
                clock_en_o <= CLK_EN_BY_SPARE[target_q];
                sel_mux_o  <= SEL_BY_SPARE[target_q];
                if (swap_count_o != {SWAP_CNT_W{1'b1}}) begin
                    swap_count_o <= swap_count_o + SWAP_CNT_W'(1);
                end
            end
        end
    end

    assign faulty_alu_o = faulty_q;
    assign stall_o      = (state_q == ALU_DRAIN) || (state_q == ALU_SWAP) || (state_q == ALU_SETTLE);
    assign degraded_o   = (state_q == ALU_DEGRADED);
    assign fatal_o      = (state_q == ALU_FAILED);

endmodule

// File: tb/tb_cv32e40p_alu_redundancy_ctrl.sv
// Scenario bench for the ALU redundancy controller: each row drives inputs for one
// cycle and queues the full output vector expected after that clock edge.
module tb_cv32e40p_alu_redundancy_ctrl;

    typedef struct packed {
        logic [3:0] ce;
        logic [2:0] sel;
        logic       stall;
        logic [3:0] faulty;
        logic       deg;
        logic       fatal;
        logic [3:0] cnt;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic [3:0] pf;
        logic       rdy;
        logic       busy;
        obs_t       exp;
    } row_t;

    logic       clk;
    logic       rst;
    logic [3:0] perm_fault;
    logic       ex_ready;
    logic       alu_busy;
    logic [2:0] sel_mux;
    logic [3:0] clock_en;
    logic       stall;
    logic [3:0] faulty_alu;
    logic       degraded;
    logic       fatal;
    logic [3:0] swap_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];

    cv32e40p_alu_redundancy_ctrl #(.SWAP_CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .perm_fault_i (perm_fault),
        .ex_ready_i   (ex_ready),
        .alu_busy_i   (alu_busy),
        .sel_mux_o    (sel_mux),
        .clock_en_o   (clock_en),
        .stall_o      (stall),
        .faulty_alu_o (faulty_alu),
        .degraded_o   (degraded),
        .fatal_o      (fatal),
        .swap_count_o (swap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t o(logic [3:0] ce, logic [2:0] sel, logic st, logic [3:0] f,
                               logic dg, logic ft, logic [3:0] c);
        obs_t v;
        v = '{ce: ce, sel: sel, stall: st, faulty: f, deg: dg, fatal: ft, cnt: c};
        return v;
    endfunction

    function automatic row_t r(logic rs, logic [3:0] pf, logic rdy, logic busy, obs_t e);
        row_t v;
        v = '{rst: rs, pf: pf, rdy: rdy, busy: busy, exp: e};
        return v;
    endfunction

    function automatic obs_t sample();
        return o(clock_en, sel_mux, stall, faulty_alu, degraded, fatal, swap_count);
    endfunction

    task automatic test_reset();
        row_t rows[$];
        obs_t got, want;
        for (int k = 0; k < 11; k++) rows.push_back(r(k == 0, 4'b0000, 1'b1, 1'b0, o(4'b0111, 3'b111, 0, 4'b0000, 0, 0, 0)));
        foreach (rows[i]) begin
            rst = rows[i].rst; perm_fault = rows[i].pf; ex_ready = rows[i].rdy; alu_busy = rows[i].busy;
            exp_q.push_back(rows[i].exp);
            @(posedge clk); #1;
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset step %0d: ce_sel_stall_faulty_deg_fatal_cnt got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_drain_swap();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(r(1, 4'b0000, 1, 0, o(4'b0111, 3'b111, 0, 4'b0000, 0, 0, 0)));
        rows.push_back(r(0, 4'b0001, 1, 0, o(4'b0111, 3'b111, 1, 4'b0001, 0, 0, 0)));
        for (int k = 0; k < 3; k++) rows.push_back(r(0, 4'b0000, 1, 1, o(4'b0111, 3'b111, 1, 4'b0001, 0, 0, 0)));
        rows.push_back(r(0, 4'b0000, 0, 0, o(4'b0111, 3'b111, 1, 4'b0001, 0, 0, 0)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b0111, 3'b111, 1, 4'b0001, 0, 0, 0)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b1110, 3'b110, 1, 4'b0001, 0, 0, 1)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b1110, 3'b110, 0, 4'b0001, 0, 0, 1)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b1110, 3'b110, 0, 4'b0001, 0, 0, 1)));
        foreach (rows[i]) begin
            rst = rows[i].rst; perm_fault = rows[i].pf; ex_ready = rows[i].rdy; alu_busy = rows[i].busy;
            exp_q.push_back(rows[i].exp);
            @(posedge clk); #1;
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL drain_swap step %0d: ce_sel_stall_faulty_deg_fatal_cnt got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_spare_fault();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(r(1, 4'b0000, 1, 0, o(4'b0111, 3'b111, 0, 4'b0000, 0, 0, 0)));
        rows.push_back(r(0, 4'b1000, 1, 0, o(4'b0111, 3'b111, 0, 4'b1000, 0, 0, 0)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b0111, 3'b111, 0, 4'b1000, 0, 0, 0)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b0111, 3'b111, 0, 4'b1000, 0, 0, 0)));
        foreach (rows[i]) begin
            rst = rows[i].rst; perm_fault = rows[i].pf; ex_ready = rows[i].rdy; alu_busy = rows[i].busy;
            exp_q.push_back(rows[i].exp);
            @(posedge clk); #1;
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL spare_fault step %0d: ce_sel_stall_faulty_deg_fatal_cnt got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_degrade_fail();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(r(1, 4'b0000, 1, 0, o(4'b0111, 3'b111, 0, 4'b0000, 0, 0, 0)));
        rows.push_back(r(0, 4'b0010, 1, 0, o(4'b0111, 3'b111, 1, 4'b0010, 0, 0, 0)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b0111, 3'b111, 1, 4'b0010, 0, 0, 0)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b1101, 3'b101, 1, 4'b0010, 0, 0, 1)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b1101, 3'b101, 0, 4'b0010, 0, 0, 1)));
        rows.push_back(r(0, 4'b0100, 1, 0, o(4'b1101, 3'b101, 0, 4'b0110, 1, 0, 1)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b1101, 3'b101, 0, 4'b0110, 1, 0, 1)));
        rows.push_back(r(0, 4'b0001, 1, 0, o(4'b1101, 3'b101, 0, 4'b0111, 0, 1, 1)));
        rows.push_back(r(0, 4'b1000, 1, 0, o(4'b1101, 3'b101, 0, 4'b1111, 0, 1, 1)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b1101, 3'b101, 0, 4'b1111, 0, 1, 1)));
        foreach (rows[i]) begin
            rst = rows[i].rst; perm_fault = rows[i].pf; ex_ready = rows[i].rdy; alu_busy = rows[i].busy;
            exp_q.push_back(rows[i].exp);
            @(posedge clk); #1;
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL degrade_fail step %0d: ce_sel_stall_faulty_deg_fatal_cnt got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_simultaneous();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(r(1, 4'b0000, 1, 0, o(4'b0111, 3'b111, 0, 4'b0000, 0, 0, 0)));
        rows.push_back(r(0, 4'b0101, 1, 0, o(4'b0111, 3'b111, 1, 4'b0101, 0, 0, 0)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b0111, 3'b111, 1, 4'b0101, 0, 0, 0)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b1110, 3'b110, 1, 4'b0101, 0, 0, 1)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b1110, 3'b110, 0, 4'b0101, 1, 0, 1)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b1110, 3'b110, 0, 4'b0101, 1, 0, 1)));
        foreach (rows[i]) begin
            rst = rows[i].rst; perm_fault = rows[i].pf; ex_ready = rows[i].rdy; alu_busy = rows[i].busy;
            exp_q.push_back(rows[i].exp);
            @(posedge clk); #1;
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL simultaneous step %0d: ce_sel_stall_faulty_deg_fatal_cnt got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_fault_during_swap();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(r(1, 4'b0000, 1, 0, o(4'b0111, 3'b111, 0, 4'b0000, 0, 0, 0)));
        rows.push_back(r(0, 4'b0001, 1, 0, o(4'b0111, 3'b111, 1, 4'b0001, 0, 0, 0)));
        rows.push_back(r(0, 4'b0100, 1, 0, o(4'b0111, 3'b111, 1, 4'b0101, 0, 0, 0)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b1110, 3'b110, 1, 4'b0101, 0, 0, 1)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b1110, 3'b110, 0, 4'b0101, 1, 0, 1)));
        foreach (rows[i]) begin
            rst = rows[i].rst; perm_fault = rows[i].pf; ex_ready = rows[i].rdy; alu_busy = rows[i].busy;
            exp_q.push_back(rows[i].exp);
            @(posedge clk); #1;
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL fault_during_swap step %0d: ce_sel_stall_faulty_deg_fatal_cnt got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_reset_in_drain();
        row_t rows[$];
        obs_t got, want;
        rows.push_back(r(1, 4'b0000, 1, 0, o(4'b0111, 3'b111, 0, 4'b0000, 0, 0, 0)));
        rows.push_back(r(0, 4'b0001, 1, 1, o(4'b0111, 3'b111, 1, 4'b0001, 0, 0, 0)));
        rows.push_back(r(0, 4'b0010, 1, 1, o(4'b0111, 3'b111, 1, 4'b0011, 0, 0, 0)));
        rows.push_back(r(1, 4'b0000, 1, 0, o(4'b0111, 3'b111, 0, 4'b0000, 0, 0, 0)));
        rows.push_back(r(0, 4'b0000, 1, 0, o(4'b0111, 3'b111, 0, 4'b0000, 0, 0, 0)));
        foreach (rows[i]) begin
            rst = rows[i].rst; perm_fault = rows[i].pf; ex_ready = rows[i].rdy; alu_busy = rows[i].busy;
            exp_q.push_back(rows[i].exp);
            @(posedge clk); #1;
            got = sample(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_in_drain step %0d: ce_sel_stall_faulty_deg_fatal_cnt got %b want %b", i, got, want);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        perm_fault = 4'b0000;
        ex_ready   = 1'b1;
        alu_busy   = 1'b0;
        test_reset();
        test_drain_swap();
        test_spare_fault();
        test_degrade_fail();
        test_simultaneous();
        test_fault_during_swap();
        test_reset_in_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
